// File: rtl/cmd_rx_pkg.sv
// cmd_rx_pkg: command frame layout and packed memory-request helpers shared by cmd_rx and cmd_tx
package cmd_rx_pkg;
  localparam int FRAME_LEN = 6;
  localparam int HDR_WR_BIT = 7;
  localparam int HDR_AINCR_BIT = 6;
  localparam int HDR_WSIZE_LSB = 4;
  localparam logic [7:0] HDR_RSVD_MASK = 8'h0F;
  localparam int MREQ_NBIT = 44;
  localparam logic [1:0] MREQ_WSIZE_VAL_1BYTE = 2'b00;
  localparam logic [1:0] MREQ_WSIZE_VAL_2BYTE = 2'b01;
  localparam logic [1:0] MREQ_WSIZE_VAL_4BYTE = 2'b10;
  typedef enum logic [1:0] {HDR, WCNT, ADDR, OUT} state_t;
  typedef struct packed {
    logic        wr;
    logic        aincr;
    logic [1:0]  wsize;
    logic [7:0]  wcount;
    logic [31:0] addr;
  } mreq_t;
  function automatic logic [MREQ_NBIT-1:0] pack_mreq(input mreq_t m);
    return {m.wr, m.aincr, m.wsize, m.wcount, m.addr};
  endfunction
  function automatic mreq_t unpack_mreq(input logic [MREQ_NBIT-1:0] v);
    return mreq_t'(v);
  endfunction
endpackage

// File: rtl/cmd_rx_if.sv
// cmd_rx_if: byte-stream input and memory-request output channels of the command parser
interface cmd_rx_if;
  import cmd_rx_pkg::*;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 mreq_valid;
  logic                 mreq_ready;
  logic [MREQ_NBIT-1:0] mreq;
  logic                 err;
  modport slave (input rx_data, rx_valid, mreq_ready, output rx_ready, mreq_valid, mreq, err);
  modport master (output rx_data, rx_valid, mreq_ready, input rx_ready, mreq_valid, mreq, err);
endinterface

// File: rtl/cmd_rx.sv
// cmd_rx: deframes 6-byte host commands into one packed memory request each, with timeout and bad-header recovery
module cmd_rx
  import cmd_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W = 17
) (
  input logic     i_clk,
  input logic     i_rst_n,
  cmd_rx_if.slave bus
);
  localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT_CYCLES);
  state_t state, state_n;
  mreq_t req, req_n;
  logic [1:0] idx, idx_n;
  logic [TIMEOUT_W-1:0] cnt, cnt_n;
  logic rdy, vld, err, err_n, acc, mid, tmo;
  always_comb begin
    acc = bus.rx_valid && rdy;
    mid = state == WCNT || state == ADDR;
    tmo = TIMEOUT_CYCLES != 0 && mid && !acc && cnt == TMAX;
    state_n = state;
    req_n = req;
    idx_n = idx;
    err_n = 1'b0;
    cnt_n = mid && !acc && TIMEOUT_CYCLES != 0 && !tmo ? cnt + 1'b1 : '0;
    case (state)
      HDR: if (acc) begin
        if ((bus.rx_data & HDR_RSVD_MASK) != 8'h00) err_n = 1'b1;
        else begin
          req_n.wr = bus.rx_data[HDR_WR_BIT];
          req_n.aincr = bus.rx_data[HDR_AINCR_BIT];
          req_n.wsize = bus.rx_data[HDR_WSIZE_LSB +: 2];
          state_n = WCNT;
        end
      end
      WCNT: if (acc) begin
        req_n.wcount = bus.rx_data;
        idx_n = 2'd0;
        state_n = ADDR;
      end else if (tmo) begin
        err_n = 1'b1;
        state_n = HDR;
      end
      ADDR: if (acc) begin
        req_n.addr[{idx, 3'b000} +: 8] = bus.rx_data;
        idx_n = idx + 2'd1;
        state_n = idx == 2'(FRAME_LEN - 3) ? OUT : ADDR;
      end else if (tmo) begin
        err_n = 1'b1;
        state_n = HDR;
      end
      default: state_n = vld && bus.mreq_ready ? HDR : OUT;
    endcase
  end
  // ready/valid are registered copies of the next state so neither depends combinationally on mreq_ready
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= HDR;
      req <= '0;
      idx <= 2'd0;
      cnt <= '0;
      err <= 1'b0;
      rdy <= 1'b1;
      vld <= 1'b0;
    end else begin
      state <= state_n;
      req <= req_n;
      idx <= idx_n;
      cnt <= cnt_n;
      err <= err_n;
      rdy <= state_n != OUT;
      vld <= state_n == OUT;
    end
  end
  assign bus.rx_ready = rdy;
  assign bus.mreq_valid = vld;
  assign bus.mreq = pack_mreq(req);
  assign bus.err = err;
endmodule

// File: tb/tb_cmd_rx.sv
// tb_cmd_rx: table, directed and randomized checks of cmd_rx against a frame-level reference model
module tb_cmd_rx;
  import cmd_rx_pkg::*;
  localparam int T = 20;
  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [47:0] frm;
    logic        bad;
    logic [43:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cmd_rx_if bus();
  cmd_rx #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(5)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  int vectors = 0, miscompares = 0;
  int rdy_mode = 0;
  logic rdy_force = 1'b0;
  logic done = 1'b0;
  byte_q_t part;
  logic [43:0] expq[$];
  int gap = 0, cyc = 0, hs_cyc = 0, acc_cyc = 0, obs_err = 0, n_hs = 0, n_exp = 0;
  logic err_due = 1'b0, valid_due = 1'b0, ready_due = 1'b0;
  vec_t tbl[7];

  always @(posedge clk) begin
    #1;
    bus.mreq_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [43:0] frame_to_mreq(input byte_q_t f);
    logic [31:0] addr;
    addr = 32'(f[2]) + 32'(f[3]) * 256 + 32'(f[4]) * 65536 + 32'(f[5]) * 16777216;
    return {f[0][7:4], f[1], addr};
  endfunction

  task automatic monitor();
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        part.delete();
        expq.delete();
        gap = 0;
        err_due = 1'b0;
        valid_due = 1'b0;
        ready_due = 1'b0;
        continue;
      end
      if (bus.err) obs_err++;
      if (bus.err || err_due) check("err_pulse", 64'(bus.err), 64'(err_due));
      if (valid_due) check("valid_latency", {bus.mreq_valid, bus.rx_ready}, 2'b10);
      if (ready_due) check("ready_after_hs", {bus.mreq_valid, bus.rx_ready}, 2'b01);
      err_due = 1'b0;
      valid_due = 1'b0;
      ready_due = 1'b0;
      if (bus.mreq_valid && bus.mreq_ready) begin
        hs_cyc = cyc;
        ready_due = 1'b1;
        n_hs++;
        if (expq.size() == 0) check("mreq_spurious", 64'(bus.mreq_valid), 64'd0);
        else check("mreq_model", 64'(bus.mreq), 64'(expq.pop_front()));
      end
      if (bus.rx_valid && bus.rx_ready) begin
        acc_cyc = cyc;
        gap = 0;
        if (part.size() == 0 && (bus.rx_data & 8'h0F) != 8'h00) err_due = 1'b1;
        else begin
          part.push_back(bus.rx_data);
          if (part.size() == 6) begin
            expq.push_back(frame_to_mreq(part));
            n_exp++;
            part.delete();
            valid_due = 1'b1;
          end
        end
      end else if (part.size() != 0) begin
        gap++;
        if (gap > T) begin
          part.delete();
          gap = 0;
          err_due = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rx_ready && n < 200);
    if (!bus.rx_ready) check("send_timeout", 64'(bus.rx_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      idle(max_gap == 0 ? 0 : int'($urandom_range(0, max_gap)));
      send_byte(f[8*i +: 8]);
    end
  endtask

  task automatic wait_valid(input string name, input logic [43:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mreq_valid && n < 100);
    check(name, 64'(bus.mreq), 64'(exp));
  endtask

  task automatic run_tests();
    int e0;
    logic [47:0] f;
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    tbl[0] = '{48'h12345678_0550, 1'b0, 44'h5_05_12345678};
    tbl[1] = '{48'h43211234_05D0, 1'b0, 44'hD_05_43211234};
    tbl[2] = '{48'h00000000_0051, 1'b1, 44'h0};
    tbl[3] = '{48'hDEADBEEF_0020, 1'b0, 44'h2_00_DEADBEEF};
    tbl[4] = '{48'h80000000_FFF0, 1'b0, 44'hF_FF_80000000};
    tbl[5] = '{48'h00000000_0088, 1'b1, 44'h0};
    tbl[6] = '{48'h00000001_0100, 1'b0, 44'h0_01_00000001};
    idle(3);
    check("reset_state", {bus.rx_ready, bus.mreq_valid, bus.err, bus.mreq}, {3'b100, 44'h0});
    rst_n = 1'b1;
    idle(2);
    foreach (tbl[i]) begin
      e0 = obs_err;
      if (tbl[i].bad) begin
        send_byte(tbl[i].frm[7:0]);
        idle(3);
        check("bad_hdr_err", 64'(obs_err - e0), 64'd1);
        check("bad_hdr_no_mreq", 64'(bus.mreq_valid), 64'd0);
      end else begin
        send_frame(tbl[i].frm, 6, 0);
        wait_valid("tbl_mreq", tbl[i].exp);
        idle(2);
        check("tbl_no_err", 64'(obs_err - e0), 64'd0);
      end
    end
    // downstream stall: request must hold and bytes must be refused
    rdy_mode = 2;
    rdy_force = 1'b0;
    idle(2);
    send_frame(tbl[1].frm, 6, 0);
    repeat (12) begin
      @(negedge clk);
      check("bp_hold", {bus.mreq_valid, bus.rx_ready, bus.mreq}, {2'b10, 44'hD_05_43211234});
    end
    rdy_force = 1'b1;
    send_byte(8'h50);
    check("bubble", 64'(acc_cyc - hs_cyc), 64'd1);
    rdy_mode = 0;
    for (int i = 1; i < 6; i++) send_byte(tbl[0].frm[8*i +: 8]);
    wait_valid("bp_next_mreq", tbl[0].exp);
    idle(2);
    e0 = obs_err;
    send_frame(tbl[0].frm, 6, 15);
    wait_valid("gaps_mreq", tbl[0].exp);
    idle(2);
    check("gaps_no_err", 64'(obs_err - e0), 64'd0);
    e0 = obs_err;
    send_frame(tbl[0].frm, 2, 0);
    idle(T);
    for (int i = 2; i < 6; i++) send_byte(tbl[0].frm[8*i +: 8]);
    wait_valid("gap_eq_t_mreq", tbl[0].exp);
    idle(2);
    check("gap_eq_t_no_err", 64'(obs_err - e0), 64'd0);
    e0 = obs_err;
    send_frame(tbl[0].frm, 3, 0);
    idle(T + 5);
    check("timeout_err", 64'(obs_err - e0), 64'd1);
    send_frame(tbl[3].frm, 6, 0);
    wait_valid("after_timeout_mreq", tbl[3].exp);
    idle(2);
    send_frame(tbl[0].frm, 3, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {bus.rx_ready, bus.mreq_valid, bus.err, bus.mreq}, {3'b100, 44'h0});
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(tbl[4].frm, 6, 0);
    wait_valid("after_rst_mreq", tbl[4].exp);
    idle(2);
    rdy_mode = 2;
    rdy_force = 1'b0;
    idle(2);
    send_frame(tbl[1].frm, 6, 0);
    wait_valid("pre_rst_out", tbl[1].exp);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_out", {bus.mreq_valid, bus.rx_ready}, 2'b01);
    idle(2);
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(1);
    send_frame(tbl[6].frm, 6, 0);
    wait_valid("after_rst_out_mreq", tbl[6].exp);
    idle(2);
    rdy_mode = 1;
    n_hs = 0;
    n_exp = 0;
    for (int k = 0; k < 40; k++) begin
      f = 48'({$urandom(), $urandom()});
      f[3:0] = $urandom_range(0, 9) == 0 ? 4'($urandom_range(1, 15)) : 4'h0;
      n = $urandom_range(0, 7) == 0 ? int'($urandom_range(1, 5)) : 6;
      for (int i = 0; i < n; i++) begin
        idle($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 12)) : 0);
        send_byte(f[8*i +: 8]);
      end
      if (n < 6) idle(T + 3);
    end
    rdy_mode = 0;
    idle(T + 5);
    check("mreq_count", 64'(n_hs), 64'(n_exp));
    check("final_idle", {bus.mreq_valid, bus.rx_ready}, 2'b01);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      run_tests();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
